// File: rtl/fifo_sample_bridge_if.sv
// rtl/fifo_sample_bridge_if.sv - FIFO read-side and Avalon-MM slave signal bundle for fifo_sample_bridge
//
// Ports carried:
//   fifo_q        FIFO read data, valid the cycle after fifo_rdreq
//   fifo_rdempty  FIFO empty flag
//   fifo_rdfull   FIFO full flag
//   fifo_rdreq    FIFO read request, one word per asserted cycle
//   avs_address   register select (0 DATA, 1 STATUS, 2 CONTROL, 3 THRESHOLD)
//   avs_read      register read strobe
//   avs_write     register write strobe
//   avs_writedata register write data
//   avs_readdata  register read data, one cycle after avs_read
//   irq           level interrupt to the CPU
// Modports: slave = bridge view, master = FIFO/CPU side view.
interface fifo_sample_bridge_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] fifo_q;
  logic              fifo_rdempty;
  logic              fifo_rdfull;
  logic              fifo_rdreq;
  logic [1:0]        avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic              irq;

  modport slave (
    input  fifo_q, fifo_rdempty, fifo_rdfull,
    input  avs_address, avs_read, avs_write, avs_writedata,
    output fifo_rdreq, avs_readdata, irq
  );

  modport master (
    output fifo_q, fifo_rdempty, fifo_rdfull,
    output avs_address, avs_read, avs_write, avs_writedata,
    input  fifo_rdreq, avs_readdata, irq
  );
endinterface

// File: rtl/fifo_sample_bridge.sv
// rtl/fifo_sample_bridge.sv - prefetches FIFO samples into a local buffer and exposes them over Avalon-MM
//
// Ports:
//   clk_clk      sole clock, rising edge
//   reset_reset  asynchronous active-high reset
//   bus          fifo_sample_bridge_if.slave (FIFO read side, register slave, irq)
// Registers: 0 DATA (RO, read pops), 1 STATUS (udf/ovf W1C), 2 CONTROL (en, irq_en, flush),
//            3 THRESHOLD (irq level).
// Optional feature: define FIFO_SAMPLE_BRIDGE_IRQ_EN to enable irq, CONTROL.irq_en and THRESHOLD;
// without it irq is tied low and those fields read 0.
module fifo_sample_bridge #(
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 8
) (
  input logic                 clk_clk,
  input logic                 reset_reset,
  fifo_sample_bridge_if.slave bus
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = LW + 1;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_THRESH  = 2'd3;

  logic [DATA_W-1:0] mem_q [BUF_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          inflight_q, inflight_d;
  logic          en_q, en_d;
  logic          udf_q, udf_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   readdata_q, readdata_d;
  logic [31:0]   thresh_rd;

`ifdef FIFO_SAMPLE_BRIDGE_IRQ_EN
  logic          irq_en_q, irq_en_d;
  logic [6:0]    thresh_q, thresh_d;
  logic          irq_q, irq_d;
`else
  logic          irq_en_q;
  assign irq_en_q = 1'b0;
`endif

  logic rd_data;
  logic wr_status;
  logic wr_ctrl;
  logic flush;
  logic push;
  logic pop;
  logic rdreq;
  logic empty;

  always_comb begin
    rd_data   = bus.avs_read  && (bus.avs_address == ADDR_DATA);
    wr_status = bus.avs_write && (bus.avs_address == ADDR_STATUS);
    wr_ctrl   = bus.avs_write && (bus.avs_address == ADDR_CONTROL);
    flush     = wr_ctrl && bus.avs_writedata[2];
    empty     = (level_q == '0);
    pop       = rd_data && !empty;
    // A word arriving in the flush cycle belongs to the discarded stream.
    push      = inflight_q && !flush;
    // Count the in-flight word so the buffer can never be over-requested.
    rdreq     = en_q && !bus.fifo_rdempty && !flush &&
                ((CW'(level_q) + CW'(inflight_q)) < CW'(BUF_DEPTH));
    inflight_d = rdreq;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end

    // Set events take priority over a same-cycle W1C clear.
    udf_d = (udf_q & ~(wr_status & bus.avs_writedata[2])) | (rd_data & empty);
    ovf_d = (ovf_q & ~(wr_status & bus.avs_writedata[3])) | bus.fifo_rdfull;
    en_d  = wr_ctrl ? bus.avs_writedata[0] : en_q;

`ifdef FIFO_SAMPLE_BRIDGE_IRQ_EN
    irq_en_d  = wr_ctrl ? bus.avs_writedata[1] : irq_en_q;
    thresh_d  = (bus.avs_write && (bus.avs_address == ADDR_THRESH)) ?
                bus.avs_writedata[6:0] : thresh_q;
    irq_d     = irq_en_q & ((7'(level_q) >= thresh_q) | udf_q | ovf_q);
    thresh_rd = {25'd0, thresh_q};
`else
    thresh_rd = 32'd0;
`endif

    // All read data comes from pre-edge state, so a same-cycle write is not visible.
    readdata_d = readdata_q;
    if (bus.avs_read) begin
      unique case (bus.avs_address)
        ADDR_DATA:    readdata_d = empty ? 32'd0 : 32'(mem_q[rd_ptr_q]);
        ADDR_STATUS:  readdata_d = {17'd0, 7'(level_q), 4'd0, ovf_q, udf_q, bus.fifo_rdfull, empty};
        ADDR_CONTROL: readdata_d = {30'd0, irq_en_q, en_q};
        default:      readdata_d = thresh_rd;
      endcase
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      inflight_q <= 1'b0;
      en_q       <= 1'b0;
      udf_q      <= 1'b0;
      ovf_q      <= 1'b0;
      readdata_q <= 32'd0;
`ifdef FIFO_SAMPLE_BRIDGE_IRQ_EN
      irq_en_q   <= 1'b0;
      thresh_q   <= 7'd1;
      irq_q      <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      inflight_q <= inflight_d;
      en_q       <= en_d;
      udf_q      <= udf_d;
      ovf_q      <= ovf_d;
      readdata_q <= readdata_d;
`ifdef FIFO_SAMPLE_BRIDGE_IRQ_EN
      irq_en_q   <= irq_en_d;
      thresh_q   <= thresh_d;
      irq_q      <= irq_d;
`endif
    end
  end

  // Storage needs no reset: level gates every read of it.
  always_ff @(posedge clk_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.fifo_q;
    end
  end

  assign bus.fifo_rdreq   = rdreq;
  assign bus.avs_readdata = readdata_q;
`ifdef FIFO_SAMPLE_BRIDGE_IRQ_EN
  assign bus.irq = irq_q;
`else
  assign bus.irq = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sample_bridge.sv
// tb/tb_fifo_sample_bridge.sv - self-checking bench for fifo_sample_bridge
`timescale 1ns/1ps
module tb_fifo_sample_bridge;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
`ifdef FIFO_SAMPLE_BRIDGE_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_sample_bridge_if #(.DATA_W(DW)) bus ();
  fifo_sample_bridge_if #(.DATA_W(16)) bus16 ();

  fifo_sample_bridge #(.DATA_W(DW), .BUF_DEPTH(DEPTH)) dut (
    .clk_clk(clk), .reset_reset(rst), .bus(bus)
  );
  fifo_sample_bridge #(.DATA_W(16), .BUF_DEPTH(DEPTH)) dut16 (
    .clk_clk(clk), .reset_reset(rst), .bus(bus16)
  );

  // External FIFO: words are pushed by the stimulus, handed out one cycle after rdreq.
  logic [31:0] src_mem [0:2047];
  int src_pushed = 0;
  int src_popped = 0;
  int rdreq_cnt  = 0;
  assign bus.fifo_rdempty = (src_pushed == src_popped);
  always @(posedge clk) begin
    if (bus.fifo_rdreq) begin
      bus.fifo_q <= src_mem[src_popped];
      src_popped <= src_popped + 1;
      rdreq_cnt  <= rdreq_cnt + 1;
    end
  end

  assign bus16.fifo_q       = 16'hBEEF;
  assign bus16.fifo_rdempty = 1'b0;
  assign bus16.fifo_rdfull  = 1'b0;

  // Reference model: buffer as a queue of words, registers as plain variables.
  logic [31:0] mbuf [$];
  bit          m_pend, m_en, m_irq_en, m_udf, m_ovf, m_irq;
  int          m_thr;
  logic [31:0] m_pend_w, exp_rd;

  always @(posedge clk or posedge rst) begin
    int lvl;
    bit uset, fl, wst;
    if (rst) begin
      mbuf.delete();
      m_pend = 0; m_en = 0; m_irq_en = 0; m_udf = 0; m_ovf = 0; m_irq = 0;
      m_thr = 1; exp_rd = 0;
    end else begin
      lvl  = mbuf.size();
      uset = 0;
      if (bus.avs_read) begin
        case (bus.avs_address)
          2'd0: begin
            if (lvl > 0) exp_rd = mbuf.pop_front();
            else begin exp_rd = 0; uset = 1; end
          end
          2'd1: exp_rd = 32'(lvl * 256 + int'(m_ovf) * 8 + int'(m_udf) * 4 +
                             int'(bus.fifo_rdfull) * 2 + int'(lvl == 0));
          2'd2: exp_rd = 32'(int'(m_en) + (IRQ_ON ? 2 * int'(m_irq_en) : 0));
          default: exp_rd = IRQ_ON ? 32'(m_thr) : 32'd0;
        endcase
      end
      m_irq = IRQ_ON && m_irq_en && (lvl >= m_thr || m_udf || m_ovf);
      fl  = bus.avs_write && bus.avs_address == 2'd2 && bus.avs_writedata[2];
      wst = bus.avs_write && bus.avs_address == 2'd1;
      if (fl) mbuf.delete();
      else if (m_pend) mbuf.push_back(m_pend_w);
      m_udf = uset | (m_udf & !(wst && bus.avs_writedata[2]));
      m_ovf = bus.fifo_rdfull | (m_ovf & !(wst && bus.avs_writedata[3]));
      if (bus.avs_write && bus.avs_address == 2'd2) begin
        m_en = bus.avs_writedata[0];
        if (IRQ_ON) m_irq_en = bus.avs_writedata[1];
      end
      if (bus.avs_write && bus.avs_address == 2'd3 && IRQ_ON) m_thr = int'(bus.avs_writedata[6:0]);
      m_pend   = bus.fifo_rdreq;
      m_pend_w = src_mem[src_popped];
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_src(input logic [31:0] w);
    src_mem[src_pushed] = w;
    src_pushed++;
  endtask

  task automatic do_read(input logic [1:0] a, output logic [31:0] d);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    @(negedge clk);
    bus.avs_read    = 1'b0;
    d = bus.avs_readdata;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] wd);
    bus.avs_address   = a;
    bus.avs_writedata = wd;
    bus.avs_write     = 1'b1;
    @(negedge clk);
    bus.avs_write     = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int base;
    rst = 1'b0;
    bus.avs_address = 0; bus.avs_read = 0; bus.avs_write = 0; bus.avs_writedata = 0;
    bus.fifo_rdfull = 0;
    bus16.avs_address = 0; bus16.avs_read = 0; bus16.avs_write = 0; bus16.avs_writedata = 0;
    #1 rst = 1'b1;
    #1;
    check("reset_rdreq", 32'(bus.fifo_rdreq), 32'd0);
    check("reset_readdata", bus.avs_readdata, 32'd0);
    check("reset_irq", 32'(bus.irq), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Fill from a FIFO holding 0x11..0x1A.
    for (int i = 0; i < 10; i++) push_src(32'h11 + 32'(i));
    do_write(2'd2, 32'h1);
    repeat (20) @(negedge clk);
    check("fill_rdreq_count", 32'(rdreq_cnt), 32'd8);
    check("fill_rdreq_idle", 32'(bus.fifo_rdreq), 32'd0);
    do_read(2'd1, d);
    check("fill_status", d, 32'h0000_0800);

    for (int i = 0; i < 10; i++) begin
      do_read(2'd0, d);
      check("drain_data", d, 32'h11 + 32'(i));
    end
    do_read(2'd0, d);
    check("underflow_data", d, 32'd0);
    do_read(2'd1, d);
    check("underflow_status", d, 32'h0000_0005);
    check("drain_rdreq_count", 32'(rdreq_cnt), 32'd10);
    do_write(2'd1, 32'h4);
    do_read(2'd1, d);
    check("udf_w1c", d, 32'h0000_0001);

    // Flush in the cycle a request would be made, level 3.
    for (int i = 0; i < 3; i++) push_src(32'h30 + 32'(i));
    repeat (6) @(negedge clk);
    do_read(2'd1, d);
    check("pre_flush_status", d, 32'h0000_0300);
    base = rdreq_cnt;
    push_src(32'h40); push_src(32'h41);
    bus.avs_address = 2'd2; bus.avs_writedata = 32'h4; bus.avs_write = 1'b1;
    #1 check("flush_rdreq", 32'(bus.fifo_rdreq), 32'd0);
    @(negedge clk);
    bus.avs_write = 1'b0;
    do_read(2'd1, d);
    check("post_flush_status", d, 32'h0000_0001);
    do_read(2'd0, d);
    check("post_flush_data", d, 32'd0);
    check("flush_rdreq_count", 32'(rdreq_cnt - base), 32'd0);
    do_write(2'd1, 32'h4);

    // Word in flight during a flush is discarded.
    base = rdreq_cnt;
    do_write(2'd2, 32'h1);
    check("inflight_rdreq", 32'(bus.fifo_rdreq), 32'd1);
    @(negedge clk);
    do_write(2'd2, 32'h4);
    do_read(2'd1, d);
    check("inflight_dropped", d, 32'h0000_0001);
    check("inflight_rdreq_count", 32'(rdreq_cnt - base), 32'd1);

    // Overflow sticky, live full flag, set-over-clear, W1C.
    bus.fifo_rdfull = 1'b1;
    do_read(2'd1, d);
    bus.fifo_rdfull = 1'b0;
    check("rdfull_live", d, 32'h0000_0003);
    do_read(2'd1, d);
    check("ovf_set", d, 32'h0000_0009);
    bus.fifo_rdfull = 1'b1;
    do_write(2'd1, 32'h8);
    bus.fifo_rdfull = 1'b0;
    do_read(2'd1, d);
    check("ovf_set_wins", d, 32'h0000_0009);
    do_write(2'd1, 32'h8);
    do_read(2'd1, d);
    check("ovf_w1c", d, 32'h0000_0001);

    // Interrupt threshold (feature may be compiled out).
    do_write(2'd1, 32'hC);
    do_write(2'd3, 32'h4);
    do_read(2'd3, d);
    check("thresh_rd", d, IRQ_ON ? 32'd4 : 32'd0);
    do_write(2'd2, 32'h3);
    do_read(2'd2, d);
    check("ctrl_rd", d, IRQ_ON ? 32'd3 : 32'd1);
    for (int i = 0; i < 5; i++) push_src(32'hA0 + 32'(i));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("irq_fill", 32'(bus.irq), 32'(m_irq));
    end
    check("irq_high", 32'(bus.irq), 32'(IRQ_ON));
    for (int i = 0; i < 3; i++) begin
      do_read(2'd0, d);
      check("irq_drain_data", d, exp_rd);
    end
    repeat (2) @(negedge clk);
    check("irq_low", 32'(bus.irq), 32'd0);

    // Reset in the middle of a fill.
    for (int i = 0; i < 5; i++) push_src(32'hC0 + 32'(i));
    repeat (2) @(negedge clk);
    do_read(2'd1, d);
    check("prereset_status", d, exp_rd);
    #2 rst = 1'b1;
    #1;
    check("midreset_rdreq", 32'(bus.fifo_rdreq), 32'd0);
    check("midreset_readdata", bus.avs_readdata, 32'd0);
    check("midreset_irq", 32'(bus.irq), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    base = rdreq_cnt;
    repeat (4) @(negedge clk);
    check("postreset_no_rdreq", 32'(rdreq_cnt - base), 32'd0);
    do_read(2'd1, d);
    check("postreset_status", d, 32'h0000_0001);
    do_write(2'd2, 32'h1);
    check("postreset_en_rdreq", 32'(bus.fifo_rdreq), 32'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      bit rd, wr, fl;
      logic [1:0] a;
      logic [31:0] wd;
      if ($urandom_range(0, 2) == 0 && src_pushed < 2000) push_src($urandom);
      bus.fifo_rdfull = ($urandom_range(0, 39) == 0);
      rd = ($urandom_range(0, 99) < 45);
      wr = ($urandom_range(0, 99) < 15);
      a  = ($urandom_range(0, 99) < 60) ? 2'd0 : 2'($urandom_range(1, 3));
      case (a)
        2'd2:    wd = {29'd0, 1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 4) != 0)};
        2'd3:    wd = 32'($urandom_range(0, 9));
        default: wd = $urandom;
      endcase
      bus.avs_address = a; bus.avs_read = rd; bus.avs_write = wr; bus.avs_writedata = wd;
      fl = wr && (a == 2'd2) && wd[2];
      #1;
      check("rnd_rdreq", 32'(bus.fifo_rdreq),
            32'(m_en && (src_pushed != src_popped) && !fl &&
                (mbuf.size() + int'(m_pend) < DEPTH)));
      check("rnd_irq", 32'(bus.irq), 32'(m_irq));
      @(negedge clk);
      bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.fifo_rdfull = 1'b0;
      if (rd) check("rnd_read", bus.avs_readdata, exp_rd);
    end

    // Narrow sample width is zero-extended.
    bus16.avs_address = 2'd2; bus16.avs_writedata = 32'h1; bus16.avs_write = 1'b1;
    @(negedge clk);
    bus16.avs_write = 1'b0;
    repeat (4) @(negedge clk);
    bus16.avs_address = 2'd0; bus16.avs_read = 1'b1;
    @(negedge clk);
    bus16.avs_read = 1'b0;
    check("data_w16", bus16.avs_readdata, 32'h0000_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
